systolic_tile_engine: RTL and testbench

//  Output-stationary N1xN2 systolic matmul tile with runtime reduction depth and valid/ready streams.

---
 rtl/systolic_tile_engine.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_tile_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_engine.sv
// Output-stationary N1xN2 systolic matmul tile. Unskewed A/B beats are skewed into a PE grid,
// accumulated over k_len beats, flushed through the wavefront, then drained one result row per beat.
module systolic_tile_engine #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int K_MAX   = 64,
    localparam int KW     = $clog2(K_MAX + 1),
    localparam int RW     = (N1 > 1) ? $clog2(N1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  acc_keep,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N1*D_W-1:0]     a_data,
    input  logic [N2*D_W-1:0]     b_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [N2*D_W_ACC-1:0] d_data,
    output logic [RW-1:0]         d_row,
    output logic                  d_last,
    output logic                  busy,
    output logic                  done
);
    localparam int FW = $clog2(N1 + N2);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic [KW-1:0] k_clamped;
    logic          beat_fire;
    logic          clear_acc;

    logic signed [D_W-1:0]     a_in   [N1];
    logic signed [D_W-1:0]     b_in   [N2];
    logic signed [D_W-1:0]     a_edge [N1];
    logic signed [D_W-1:0]     b_edge [N2];
    logic signed [D_W-1:0]     a_pe   [N1][N2];
    logic signed [D_W-1:0]     b_pe   [N1][N2];
    logic signed [D_W_ACC-1:0] acc_pe [N1][N2];

    assign k_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign beat_fire = (state_q == LOAD) && in_valid;
    assign clear_acc = (state_q == IDLE) && start && !acc_keep;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = k_clamped;
                    cnt_d   = '0;
                    state_d = (k_clamped == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q + KW'(1) == k_q) begin
                        cnt_d   = '0;
                        fl_d    = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + KW'(1);
                    end
                end
            end
            FLUSH: begin
                // The last beat needs N1+N2-1 more edges to reach PE(N1-1,N2-1).
                if (fl_q == FW'(N1 + N2 - 2)) begin
                    fl_d    = '0;
                    state_d = DRAIN;
                end else begin
                    fl_d = fl_q + FW'(1);
                end
            end
            DRAIN: begin
                if (d_ready) begin
                    if (row_q == RW'(N1 - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Bubbles and non-LOAD cycles feed zeros, so they never contribute to any accumulator.
    always_comb begin
        for (int i = 0; i < N1; i++) a_in[i] = beat_fire ? a_data[i*D_W +: D_W] : '0;
        for (int j = 0; j < N2; j++) b_in[j] = beat_fire ? b_data[j*D_W +: D_W] : '0;
    end

    for (genvar gi = 0; gi < N1; gi++) begin : g_a_skew
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_in[gi];
        end else begin : g_delay
            logic signed [D_W-1:0] sk_q [gi];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) sk_q[d] <= '0;
                end else begin
                    sk_q[0] <= a_in[gi];
                    for (int d = 1; d < gi; d++) sk_q[d] <= sk_q[d-1];
                end
            end
            assign a_edge[gi] = sk_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < N2; gj++) begin : g_b_skew
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = b_in[gj];
        end else begin : g_delay
            logic signed [D_W-1:0] sk_q [gj];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < gj; d++) sk_q[d] <= '0;
                end else begin
                    sk_q[0] <= b_in[gj];
                    for (int d = 1; d < gj; d++) sk_q[d] <= sk_q[d-1];
                end
            end
            assign b_edge[gj] = sk_q[gj-1];
        end
    end

    for (genvar gi = 0; gi < N1; gi++) begin : g_row
        for (genvar gj = 0; gj < N2; gj++) begin : g_col
            logic signed [D_W-1:0]     a_q, b_q, a_src, b_src;
            logic signed [2*D_W-1:0]   prod;
            logic signed [D_W_ACC-1:0] acc_q;

            if (gj == 0) begin : g_a_first
                assign a_src = a_edge[gi];
            end else begin : g_a_fwd
                assign a_src = a_pe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_first
                assign b_src = b_edge[gj];
            end else begin : g_b_fwd
                assign b_src = b_pe[gi-1][gj];
            end

            assign prod = a_q * b_q;

            // NOTE: the accumulator array is reset explicitly so an aborted job leaves no residue.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_src;
                    b_q   <= b_src;
                    acc_q <= clear_acc ? '0 : acc_q + D_W_ACC'(prod);
                end
            end

            assign a_pe[gi][gj]   = a_q;
            assign b_pe[gi][gj]   = b_q;
            assign acc_pe[gi][gj] = acc_q;
        end
    end

    always_comb begin
        d_data = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < N2; j++) d_data[j*D_W_ACC +: D_W_ACC] = acc_pe[row_q][j];
        end
    end

    assign in_ready = (state_q == LOAD);
    assign d_valid  = (state_q == DRAIN);
    assign d_row    = row_q;
    assign d_last   = (state_q == DRAIN) && (row_q == RW'(N1 - 1));
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: stimulus pushes expected result rows into a scoreboard,
// an independent monitor pops and compares every accepted result beat.
module tb_systolic_tile_engine;
    localparam int D_W     = 8;
    localparam int D_W_ACC = 16;
    localparam int N1      = 4;
    localparam int N2      = 4;
    localparam int K_MAX   = 64;
    localparam int KW      = $clog2(K_MAX + 1);

    logic                  clk = 1'b0;
    logic                  rst, start, acc_keep, in_valid, d_ready;
    logic [KW-1:0]         k_len;
    logic [N1*D_W-1:0]     a_data;
    logic [N2*D_W-1:0]     b_data;
    logic                  in_ready, d_valid, d_last, busy, done;
    logic [N2*D_W_ACC-1:0] d_data;
    logic [1:0]            d_row;

    systolic_tile_engine #(
        .D_W(D_W), .D_W_ACC(D_W_ACC), .N1(N1), .N2(N2), .K_MAX(K_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_keep(acc_keep),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_row(d_row),
        .d_last(d_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  row;
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   job_done0 = 0;

    int ma   [N1][K_MAX];
    int mb   [K_MAX][N2];
    int macc [N1][N2];
    logic [63:0] exp1 [N1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] pack4(input int v0, input int v1, input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    task automatic push_exp(input int i, input logic [63:0] data);
        exp_t e;
        e.row  = 2'(i);
        e.data = data;
        e.last = (i == N1 - 1);
        sb.push_back(e);
    endtask

    function automatic logic [63:0] model_row(input int i);
        logic [63:0] r;
        for (int j = 0; j < N2; j++) r[j*16 +: 16] = 16'(macc[i][j]);
        return r;
    endfunction

    task automatic model_job(input int k, input bit keep);
        for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++) begin
                if (!keep) macc[i][j] = 0;
                for (int t = 0; t < k; t++) macc[i][j] += ma[i][t] * mb[t][j];
            end
    endtask

    task automatic push_identity();
        for (int i = 0; i < N1; i++) push_exp(i, pack4(4*i+1, 4*i+2, 4*i+3, 4*i+4));
    endtask

    task automatic load_identity();
        for (int i = 0; i < N1; i++)
            for (int t = 0; t < N1; t++) ma[i][t] = (i == t) ? 1 : 0;
        for (int t = 0; t < N1; t++)
            for (int j = 0; j < N2; j++) mb[t][j] = 4*t + j + 1;
    endtask

    task automatic run_job(input int klen, input int nbeats, input bit keep, input int gap_pct,
                           input bit timed, input bit stall, input bit use_model);
        int t, guard, s0;
        bit fire;
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        model_job(nbeats, keep);
        if (use_model) for (int i = 0; i < N1; i++) push_exp(i, model_row(i));
        guard = 0;
        while (busy && guard < 500) begin @(posedge clk); #1; guard++; end
        check("idle_wait", busy, 0);
        start = 1'b1; k_len = KW'(klen); acc_keep = keep; d_ready = !stall;
        @(posedge clk); #1;
        start = 1'b0;
        s0 = cyc;
        job_done0 = done_cnt;
        t = 0; guard = 0;
        while (t < nbeats && guard < 4000) begin
            in_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
            for (int i = 0; i < N1; i++) a_data[i*D_W +: D_W] = 8'(ma[i][t]);
            for (int j = 0; j < N2; j++) b_data[j*D_W +: D_W] = 8'(mb[t][j]);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) t++;
            guard++;
        end
        in_valid = 1'b0;
        check("beats_accepted", 64'(t), 64'(nbeats));
        check("ready_drop", in_ready, 0);
        guard = 0;
        while (!d_valid && guard < 300) begin @(posedge clk); #1; guard++; end
        check("drain_reached", d_valid, 1);
        if (timed) check("latency", 64'(cyc - s0 + 1), 64'(klen + N1 + N2));
        if (stall) begin
            for (int p = 0; p < 7; p++) begin d_ready = pat[p]; @(posedge clk); #1; end
            d_ready = 1'b1;
        end
        guard = 0;
        while (!done && guard < 100) begin @(posedge clk); #1; guard++; end
        check("done_seen", done, 1);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data  = '0;
        logic [1:0]  prev_row   = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (d_valid && prev_stall) begin
                    check("stall_data", d_data, prev_data);
                    check("stall_row", d_row, prev_row);
                end
                if (d_valid && d_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("d_row", d_row, e.row);
                        check("d_data", d_data, e.data);
                        check("d_last", d_last, e.last);
                    end
                end
                prev_stall = d_valid && !d_ready;
                prev_data  = d_data;
                prev_row   = d_row;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; acc_keep = 1'b0; in_valid = 1'b0; d_ready = 1'b1;
        k_len = '0; a_data = '0; b_data = '0;
        foreach (macc[i, j]) macc[i][j] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_last", d_last, 0);
        check("rst_done", done, 0);
        check("rst_d_row", d_row, 0);
        check("rst_d_data", d_data, 0);

        // Identity A: result rows equal B rows; also the no-stall latency.
        load_identity();
        push_identity();
        run_job(4, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // k_len=0 with acc_keep: drains the retained identity result.
        push_identity();
        run_job(0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // -128*-128 summed 4 times = 65536, wraps to 0.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N1; i++) ma[i][t] = -128;
            for (int j = 0; j < N2; j++) mb[t][j] = -128;
        end
        for (int i = 0; i < N1; i++) push_exp(i, pack4(0, 0, 0, 0));
        run_job(4, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // -128*127 once = -16256.
        for (int i = 0; i < N1; i++) ma[i][0] = -128;
        for (int j = 0; j < N2; j++) mb[0][j] = 127;
        for (int i = 0; i < N1; i++) push_exp(i, pack4(-16256, -16256, -16256, -16256));
        run_job(1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Back-pressure on the result stream: order, stability, exactly one done.
        load_identity();
        push_identity();
        run_job(4, 4, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("single_done", 64'(done_cnt - job_done0), 1);

        // Random operands, gapless then with 50% input bubbles.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < N1; i++) ma[i][t] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < N2; j++) mb[t][j] = int'($urandom_range(255)) - 128;
        end
        run_job(7, 7, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        run_job(7, 7, 1'b0, 50, 1'b0, 1'b0, 1'b1);

        // Accumulate across jobs: 1x, then 2x with acc_keep, then 1x after clearing.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N1; i++) ma[i][t] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < N2; j++) mb[t][j] = int'($urandom_range(255)) - 128;
        end
        run_job(5, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N1; i++) exp1[i] = model_row(i);
        for (int i = 0; i < N1; i++) begin
            logic [63:0] dbl;
            for (int j = 0; j < N2; j++) dbl[j*16 +: 16] = 16'(exp1[i][j*16 +: 16] * 2);
            push_exp(i, dbl);
        end
        run_job(5, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N1; i++) push_exp(i, exp1[i]);
        run_job(5, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // k_len above K_MAX clamps to 64 beats of 1*1.
        for (int t = 0; t < K_MAX; t++) begin
            for (int i = 0; i < N1; i++) ma[i][t] = 1;
            for (int j = 0; j < N2; j++) mb[t][j] = 1;
        end
        for (int i = 0; i < N1; i++) push_exp(i, pack4(64, 64, 64, 64));
        run_job(100, 64, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Reset after two of four beats, then an acc_keep identity job must be clean.
        load_identity();
        while (busy) begin @(posedge clk); #1; end
        start = 1'b1; k_len = KW'(4); acc_keep = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1;
            for (int i = 0; i < N1; i++) a_data[i*D_W +: D_W] = 8'(ma[i][t]);
            for (int j = 0; j < N2; j++) b_data[j*D_W +: D_W] = 8'(mb[t][j]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        foreach (macc[i, j]) macc[i][j] = 0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_d_valid", d_valid, 0);
        check("abort_done", done, 0);
        check("abort_d_row", d_row, 0);
        check("abort_d_data", d_data, 0);
        push_identity();
        run_job(4, 4, 1'b1, 0, 1'b1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1 check("sb_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
